// File: rtl/exception_override_unit_if.sv
// Pipeline-side bundle of the exception override unit: EX exception code,
// normal writeback request, register-file write port and hazard controls.
interface exception_override_unit_if;
  logic       exc_valid_i;
  logic [1:0] exc_code_i;
  logic       wb_en_i;
  logic [2:0] wb_addr_i;
  logic [7:0] wb_data_i;
  logic       rf_we_o;
  logic [2:0] rf_addr_o;
  logic [7:0] rf_data_o;
  logic       flush_o;
  logic       stall_o;

  // Pipeline side: produces exception/writeback requests, consumes RF port and hazards
  modport master (
    output exc_valid_i, exc_code_i, wb_en_i, wb_addr_i, wb_data_i,
    input  rf_we_o, rf_addr_o, rf_data_o, flush_o, stall_o
  );

  // Override unit side
  modport slave (
    input  exc_valid_i, exc_code_i, wb_en_i, wb_addr_i, wb_data_i,
    output rf_we_o, rf_addr_o, rf_data_o, flush_o, stall_o
  );
endinterface

// File: rtl/exception_override_unit.sv
// Writeback-side overflow handler: squashes the faulting instruction, writes the
// 16-bit saturated value as two bytes over two stalled cycles, buffers one
// colliding writeback for a later drain, and counts accepted exceptions.
module exception_override_unit #(
  parameter logic [2:0]  HI_REG = 3'd1,
  parameter logic [2:0]  LO_REG = 3'd0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  exception_override_unit_if.slave bus,
  output logic [CNT_W-1:0]       exc_count_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO, DRAIN} state_t;

  state_t     state, state_nxt;
  logic [1:0] code_q;
  logic       pend_v;
  logic [2:0] pend_addr;
  logic [7:0] pend_data;

  logic code_sat;
  logic accept;
  logic illegal;
  logic capture;
  logic pend_hits_override;

  assign code_sat = (bus.exc_code_i == 2'b01) || (bus.exc_code_i == 2'b10);
  assign accept   = rst_n && (state == IDLE) && bus.exc_valid_i && code_sat;
  assign illegal  = (state == IDLE) && bus.exc_valid_i && (bus.exc_code_i == 2'b11);
  assign capture  = ((state == WR_HI) || (state == WR_LO)) && bus.wb_en_i;
  assign pend_hits_override = (pend_addr == HI_REG) || (pend_addr == LO_REG);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and register-file / hazard outputs
  always_comb begin
    state_nxt     = state;
    bus.rf_we_o   = 1'b0;
    bus.rf_addr_o = '0;
    bus.rf_data_o = '0;
    bus.stall_o   = 1'b0;
    bus.flush_o   = accept;
    case (state)
      IDLE: begin
        bus.rf_we_o   = bus.wb_en_i;
        bus.rf_addr_o = bus.wb_addr_i;
        bus.rf_data_o = bus.wb_data_i;
        if (accept) state_nxt = WR_HI;
      end
      WR_HI: begin
        bus.rf_we_o   = 1'b1;
        bus.rf_addr_o = HI_REG;
        bus.rf_data_o = (code_q == 2'b01) ? 8'h7F : 8'h80;
        bus.stall_o   = 1'b1;
        state_nxt     = WR_LO;
      end
      WR_LO: begin
        bus.rf_we_o   = 1'b1;
        bus.rf_addr_o = LO_REG;
        bus.rf_data_o = (code_q == 2'b01) ? 8'hFF : 8'h00;
        bus.stall_o   = 1'b1;
        // A writeback captured in this same cycle must also be drained
        state_nxt     = (pend_v || bus.wb_en_i) ? DRAIN : IDLE;
      end
      DRAIN: begin
        bus.stall_o = 1'b1;
        // An older pending write to an override register loses to the override
        if (!pend_hits_override) begin
          bus.rf_we_o   = 1'b1;
          bus.rf_addr_o = pend_addr;
          bus.rf_data_o = pend_data;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset forces every output low immediately, including IDLE pass-through
    if (!rst_n) begin
      state_nxt     = IDLE;
      bus.rf_we_o   = 1'b0;
      bus.rf_addr_o = '0;
      bus.rf_data_o = '0;
      bus.stall_o   = 1'b0;
    end
  end

  // Latched code, pending buffer, saturating counter and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q      <= '0;
      pend_v      <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      exc_count_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if (accept) begin
        code_q <= bus.exc_code_i;
        if (exc_count_o != '1) exc_count_o <= exc_count_o + CNT_W'(1);
      end
      if (illegal) err_o <= 1'b1;
      if (capture) begin
        if (pend_v) begin
          err_o <= 1'b1;
        end else begin
          pend_v    <= 1'b1;
          pend_addr <= bus.wb_addr_i;
          pend_data <= bus.wb_data_i;
        end
      end
      if (state == DRAIN) pend_v <= 1'b0;
    end
  end

endmodule
